// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - two-port round-robin front end for a shared divider with bypass and result cache
module div_arbiter #(
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_func3,
  input  logic [31:0]      req0_rs1,
  input  logic [31:0]      req0_rs2,
  input  logic [TAG_W-1:0] req0_tag,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_func3,
  input  logic [31:0]      req1_rs1,
  input  logic [31:0]      req1_rs2,
  input  logic [TAG_W-1:0] req1_tag,
  // response
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_port,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_rd,
  // shared divider
  output logic             div_go,
  output logic [1:0]       div_func3,
  output logic [31:0]      div_rs1,
  output logic [31:0]      div_rs2,
  input  logic             div_done,
  input  logic [31:0]      div_rd
);

  localparam logic [31:0] MIN_INT  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // r_decode marks the IDLE cycle right after acceptance, in which the
  // latched operands are classified (bypass or divider) and no new
  // request may be taken.
  logic             r_decode;
  // Port that wins when both requesters are valid.
  logic             r_prio;

  // Operation in flight.
  logic [1:0]       r_op_func3;
  logic [31:0]      r_op_rs1;
  logic [31:0]      r_op_rs2;
  logic [TAG_W-1:0] r_op_tag;
  logic             r_op_port;
  logic [31:0]      r_resp_rd;

  // Last divider-computed operation and its result.
  logic             r_cache_valid;
  logic [1:0]       r_cache_func3;
  logic [31:0]      r_cache_rs1;
  logic [31:0]      r_cache_rs2;
  logic [31:0]      r_cache_rd;

  logic             w_any;
  logic             w_grant;
  logic             w_accept;
  logic             w_div0;
  logic             w_ovf;
  logic             w_hit;
  logic             w_bypass;
  logic [31:0]      w_bypass_rd;
  logic             w_capture;

  // Round-robin grant and acceptance of a new request.
  always_comb begin
    w_any    = req0_valid | req1_valid;
    w_grant  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = r_prio;
    end else begin
      w_grant = req1_valid;
    end
    w_accept = !clr && (r_state == IDLE) && !r_decode && w_any;
  end

  // Classify the latched operation: divide by zero, signed overflow or cache hit.
  always_comb begin
    w_div0      = (r_op_rs2 == 32'd0);
    w_ovf       = !r_op_func3[0] && (r_op_rs1 == MIN_INT) && (r_op_rs2 == ALL_ONES);
    w_hit       = r_cache_valid && (r_cache_func3 == r_op_func3) &&
                  (r_cache_rs1 == r_op_rs1) && (r_cache_rs2 == r_op_rs2);
    w_bypass    = w_div0 | w_ovf | w_hit;
    w_bypass_rd = r_cache_rd;
    if (w_div0) begin
      w_bypass_rd = r_op_func3[1] ? r_op_rs1 : ALL_ONES;
    end else if (w_ovf) begin
      w_bypass_rd = r_op_func3[1] ? 32'd0 : MIN_INT;
    end
    w_capture   = (r_state == WAIT) && div_done;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; div_done only matters while waiting on the divider.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_decode) begin
          w_next = w_bypass ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Outputs; everything is forced to zero while clr is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    div_go     = 1'b0;
    resp_valid = 1'b0;
    resp_port  = 1'b0;
    resp_tag   = '0;
    resp_rd    = 32'd0;
    div_func3  = 2'd0;
    div_rs1    = 32'd0;
    div_rs2    = 32'd0;
    if (!clr) begin
      req0_ready = w_accept && !w_grant;
      req1_ready = w_accept && w_grant;
      div_go     = (r_state == ISSUE);
      resp_valid = (r_state == RESP);
      resp_port  = r_op_port;
      resp_tag   = r_op_tag;
      resp_rd    = r_resp_rd;
      div_func3  = r_op_func3;
      div_rs1    = r_op_rs1;
      div_rs2    = r_op_rs2;
    end
  end

  // Operand latch, result capture, cache and round-robin pointer.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_decode      <= 1'b0;
      r_prio        <= 1'b0;
      r_op_func3    <= 2'd0;
      r_op_rs1      <= 32'd0;
      r_op_rs2      <= 32'd0;
      r_op_tag      <= '0;
      r_op_port     <= 1'b0;
      r_resp_rd     <= 32'd0;
      r_cache_valid <= 1'b0;
      r_cache_func3 <= 2'd0;
      r_cache_rs1   <= 32'd0;
      r_cache_rs2   <= 32'd0;
      r_cache_rd    <= 32'd0;
    end else begin
      r_decode <= w_accept;
      if (w_accept) begin
        r_prio    <= ~w_grant;
        r_op_port <= w_grant;
        if (w_grant) begin
          r_op_func3 <= req1_func3;
          r_op_rs1   <= req1_rs1;
          r_op_rs2   <= req1_rs2;
          r_op_tag   <= req1_tag;
        end else begin
          r_op_func3 <= req0_func3;
          r_op_rs1   <= req0_rs1;
          r_op_rs2   <= req0_rs2;
          r_op_tag   <= req0_tag;
        end
      end
      if (r_decode && (r_state == IDLE) && w_bypass) begin
        r_resp_rd <= w_bypass_rd;
      end
      if (w_capture) begin
        r_resp_rd     <= div_rd;
        r_cache_valid <= 1'b1;
        r_cache_func3 <= r_op_func3;
        r_cache_rs1   <= r_op_rs1;
        r_cache_rs2   <= r_op_rs2;
        r_cache_rd    <= div_rd;
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed vector bench for div_arbiter
module tb_div_arbiter;

  logic        clk;
  logic        clr;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_func3, req1_func3;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [2:0]  req0_tag, req1_tag;
  logic        resp_valid, resp_ready, resp_port;
  logic [2:0]  resp_tag;
  logic [31:0] resp_rd;
  logic        div_go;
  logic [1:0]  div_func3;
  logic [31:0] div_rs1, div_rs2;
  logic        div_done;
  logic [31:0] div_rd;

  div_arbiter #(.TAG_W(3)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_func3(req0_func3),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_func3(req1_func3),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port),
    .resp_tag(resp_tag), .resp_rd(resp_rd),
    .div_go(div_go), .div_func3(div_func3), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_done(div_done), .div_rd(div_rd)
  );

  typedef struct packed {
    logic        port;
    logic [1:0]  func3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  tag;
    logic [31:0] exp_rd;
    logic        exp_go;
    logic [7:0]  lat;
    logic [7:0]  hold;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_go = 0;
  int   go_cyc = 0;
  int   div_lat = 4;
  logic stab_bad = 1'b0;
  vec_t vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (div_go === 1'b1) begin
      n_go   <= n_go + 1;
      go_cyc <= cyc;
    end
  end

  function automatic logic [31:0] div_model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Shared divider model: answers each go after div_lat cycles.
  initial begin : divider
    logic [1:0]  m_f;
    logic [31:0] m_a, m_b;
    int          lat;
    div_done = 1'b0;
    div_rd   = 32'd0;
    forever begin
      @(negedge clk);
      if (div_go === 1'b1) begin
        m_f = div_func3;
        m_a = div_rs1;
        m_b = div_rs2;
        lat = div_lat;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (div_func3 !== m_f || div_rs1 !== m_a || div_rs2 !== m_b) stab_bad = 1'b1;
        end
        div_rd   = div_model(m_f, m_a, m_b);
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic p, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] t, input logic v);
    if (p) begin
      req1_func3 = f; req1_rs1 = a; req1_rs2 = b; req1_tag = t; req1_valid = v;
    end else begin
      req0_func3 = f; req0_rs1 = a; req0_rs2 = b; req0_tag = t; req0_valid = v;
    end
  endtask

  task automatic do_op(input vec_t v, input string nm);
    int   acc_cyc, resp_cyc, n0, w;
    logic got, rdy, other;
    div_lat  = int'(v.lat);
    n0       = n_go;
    stab_bad = 1'b0;
    @(negedge clk);
    set_req(v.port, v.func3, v.rs1, v.rs2, v.tag, 1'b1);
    #1;
    w = 0;
    rdy = v.port ? req1_ready : req0_ready;
    while (!rdy && w < 10) begin
      @(negedge clk); #1;
      rdy = v.port ? req1_ready : req0_ready;
      w++;
    end
    other = v.port ? req0_ready : req1_ready;
    chk({nm, " ready"}, {31'd0, rdy}, 32'd1);
    chk({nm, " other ready"}, {31'd0, other}, 32'd0);
    acc_cyc = cyc;
    @(negedge clk);
    set_req(v.port, v.func3, v.rs1, v.rs2, v.tag, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (resp_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    resp_cyc = cyc;
    chk({nm, " resp_valid"}, {31'd0, got}, 32'd1);
    chk({nm, " rd"}, resp_rd, v.exp_rd);
    chk({nm, " tag"}, {29'd0, resp_tag}, {29'd0, v.tag});
    chk({nm, " port"}, {31'd0, resp_port}, {31'd0, v.port});
    chk({nm, " go count"}, n_go - n0, v.exp_go ? 32'd1 : 32'd0);
    if (v.exp_go) begin
      chk({nm, " div latency"}, resp_cyc - go_cyc, int'(v.lat) + 1);
      chk({nm, " operands stable"}, {31'd0, stab_bad}, 32'd0);
    end else begin
      chk({nm, " bypass latency"}, resp_cyc - acc_cyc, 32'd2);
    end
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      chk({nm, " stall valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " stall rd"}, resp_rd, v.exp_rd);
      chk({nm, " stall tag/port"}, {28'd0, resp_tag, resp_port}, {28'd0, v.tag, v.port});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, " idle after handshake"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin : main
    int   n0;
    logic got, seen;
    logic [31:0] exp_rd;

    vecs[0]  = '{1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2,        3'd5, 32'hFFFF_FFFD, 1'b1, 8'd33, 8'd0};
    vecs[1]  = '{1'b0, 2'b10, 32'h0000_1234, 32'd0,        3'd1, 32'h0000_1234, 1'b0, 8'd0,  8'd0};
    vecs[2]  = '{1'b1, 2'b00, 32'h0000_1234, 32'd0,        3'd2, 32'hFFFF_FFFF, 1'b0, 8'd0,  8'd0};
    vecs[3]  = '{1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 32'h8000_0000, 1'b0, 8'd0,  8'd0};
    vecs[4]  = '{1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h0000_0000, 1'b0, 8'd0,  8'd0};
    vecs[5]  = '{1'b0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 1'b1, 8'd1,  8'd0};
    vecs[6]  = '{1'b0, 2'b01, 32'd100,       32'd7,        3'd7, 32'd14,        1'b1, 8'd4,  8'd3};
    vecs[7]  = '{1'b1, 2'b01, 32'd100,       32'd7,        3'd0, 32'd14,        1'b0, 8'd0,  8'd0};
    vecs[8]  = '{1'b0, 2'b11, 32'd100,       32'd7,        3'd1, 32'd2,         1'b1, 8'd4,  8'd0};
    vecs[9]  = '{1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2,        3'd2, 32'hFFFF_FFFF, 1'b1, 8'd2,  8'd0};
    vecs[10] = '{1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2,        3'd3, 32'hFFFF_FFFF, 1'b0, 8'd0,  8'd2};

    clr = 1'b1;
    resp_ready = 1'b0;
    set_req(1'b0, 2'b01, 32'd55, 32'd3, 3'd7, 1'b1);
    set_req(1'b1, 2'b10, 32'd66, 32'd4, 3'd6, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset div_go", {31'd0, div_go}, 32'd0);
    chk("reset ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("reset resp fields", {28'd0, resp_tag, resp_port}, 32'd0);
    chk("reset resp_rd", resp_rd, 32'd0);
    chk("reset div_rs1", div_rs1, 32'd0);
    chk("reset div_rs2", div_rs2, 32'd0);
    chk("reset div_func3", {30'd0, div_func3}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    chk("no go after reset", n_go, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while the divider is busy; the late div_done must be ignored.
    n0 = n_go;
    div_lat = 20;
    @(negedge clk);
    set_req(1'b0, 2'b11, 32'd100, 32'd7, 3'd4, 1'b1);
    #1;
    chk("rst accept", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk); #1;
      if (n_go != n0) got = 1'b1;
    end
    chk("rst go issued", {31'd0, got}, 32'd1);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("rst mid resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst mid ready", {31'd0, req0_ready}, 32'd0);
    chk("rst mid div_rs1", div_rs1, 32'd0);
    chk("rst mid resp_rd", resp_rd, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    req0_valid = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 30; w++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    chk("rst no response", {31'd0, seen}, 32'd0);
    chk("rst no extra go", n_go - n0, 32'd1);
    do_op('{1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, 3'd1, 32'hFFFF_FFFF, 1'b1, 8'd3, 8'd0}, "rst cache cleared");
    do_op('{1'b1, 2'b11, 32'd100,       32'd7, 3'd7, 32'd2,         1'b1, 8'd2, 8'd0}, "rst reissue");

    // Both ports valid back to back: grants alternate starting at port 0.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n0 = n_go;
    set_req(1'b0, 2'b11, 32'h0000_00A0, 32'd0, 3'd6, 1'b1);
    set_req(1'b1, 2'b01, 32'h0000_00B1, 32'd0, 3'd2, 1'b1);
    #1;
    chk("arb first grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (resp_valid === 1'b1) got = 1'b1;
      end
      exp_rd = (i % 2 == 0) ? 32'h0000_00A0 : 32'hFFFF_FFFF;
      chk($sformatf("arb%0d resp_valid", i), {31'd0, got}, 32'd1);
      chk($sformatf("arb%0d port", i), {31'd0, resp_port}, i % 2);
      chk($sformatf("arb%0d tag", i), {29'd0, resp_tag}, (i % 2 == 0) ? 32'd6 : 32'd2);
      chk($sformatf("arb%0d rd", i), resp_rd, exp_rd);
      if (i == 0) begin
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          chk("arb stall valid", {31'd0, resp_valid}, 32'd1);
          chk("arb stall rd", resp_rd, exp_rd);
          chk("arb stall tag/port", {28'd0, resp_tag, resp_port}, {28'd0, 3'd6, 1'b0});
        end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("arb idle", {31'd0, resp_valid}, 32'd0);
    chk("arb no go", n_go - n0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
